// File: rtl/ds_capture_if.sv
// Sample stream and buffer read port of the downsampler capture block.
// The master drives samples and read requests; the slave returns read data.
interface ds_capture_if #(
  parameter int DW = 16,
  parameter int AW = 10
);
  logic [DW-1:0]   i_x;
  logic [DW-1:0]   i_y;
  logic            i_ce;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [2*DW-1:0] rd_data;
  logic            rd_valid;

  modport master (
    output i_x, i_y, i_ce, rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  i_x, i_y, i_ce, rd_en, rd_addr,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/ds_capture.sv
// Triggered I/Q capture buffer: arms, waits for an immediate or level-crossing
// trigger on i_y, then stores `length` sample pairs for readback.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no capture in progress, i_ce ignored
// ARMED   | waiting for the trigger sample, tracking the previous i_y
// CAPTURE | writing one sample pair per i_ce until length is reached
// DONE    | capture complete, buffer holds the result, i_ce ignored
module ds_capture #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  ds_capture_if.slave   bus,
  input  logic          arm,
  input  logic          abort,
  input  logic          trig_mode,
  input  logic [DW-1:0] threshold,
  input  logic [AW:0]   length,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   wr_count
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW:0]     wr_count_q, wr_count_d;
  logic [AW:0]     len_q, len_d;
  logic            mode_q, mode_d;
  logic [DW-1:0]   prev_q, prev_d;
  logic            prev_vld_q, prev_vld_d;
  logic [2*DW-1:0] rd_data_q;
  logic            rd_valid_q;

  logic            we;
  logic [AW-1:0]   waddr;
  logic [2*DW-1:0] wdata;
  logic            trig;
  logic [AW:0]     wr_inc;

  logic [2*DW-1:0] mem [0:(1<<AW)-1];

  assign wr_inc = wr_count_q + ONE;

  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    len_d      = len_q;
    mode_d     = mode_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    we         = 1'b0;
    waddr      = wr_count_q[AW-1:0];
    wdata      = {bus.i_x, bus.i_y};
    trig       = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            state_d    = S_ARMED;
            wr_count_d = '0;
            // zero or oversize lengths fill the whole buffer
            len_d      = (length == '0 || length > DEPTH) ? DEPTH : length;
            mode_d     = trig_mode;
            prev_vld_d = 1'b0;
          end
        end
        S_ARMED: begin
          if (bus.i_ce) begin
            prev_d     = bus.i_y;
            prev_vld_d = 1'b1;
            trig = !mode_q ||
                   (prev_vld_q &&
                    ($signed(prev_q) < $signed(threshold)) &&
                    ($signed(bus.i_y) >= $signed(threshold)));
            if (trig) begin
              we         = 1'b1;
              waddr      = '0;
              wr_count_d = ONE;
              state_d    = (len_q == ONE) ? S_DONE : S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (bus.i_ce) begin
            we         = 1'b1;
            wr_count_d = wr_inc;
            if (wr_inc == len_q) state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_count_q <= '0;
      len_q      <= DEPTH;
      mode_q     <= 1'b0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      len_q      <= len_d;
      mode_q     <= mode_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // read samples the array before this cycle's write lands: old data on collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= mem[bus.rd_addr];
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign busy         = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done         = (state_q == S_DONE);
  assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_ds_capture.sv
// Self-checking bench for ds_capture: status checks inline, buffer reads
// checked through a queue of expected words popped on rd_valid.
module tb_ds_capture;
  localparam int DW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          trig_mode = 1'b0;
  logic [DW-1:0] threshold = '0;
  logic [AW:0]   length = '0;
  logic          busy;
  logic          done;
  logic [AW:0]   wr_count;

  always #5 clk = ~clk;

  ds_capture_if #(.DW(DW), .AW(AW)) bus ();

  ds_capture #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .arm       (arm),
    .abort     (abort),
    .trig_mode (trig_mode),
    .threshold (threshold),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .wr_count  (wr_count)
  );

  int              n_chk = 0;
  int              n_fail = 0;
  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] last_rd = '0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rd_valid) begin
      check_val("rd_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check_val("rd_data", bus.rd_data, exp_q.pop_front());
      last_rd <= bus.rd_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [DW-1:0] x, input logic [DW-1:0] y);
    bus.i_x  = x;
    bus.i_y  = y;
    bus.i_ce = 1'b1;
    tick();
    bus.i_ce = 1'b0;
  endtask

  task automatic do_arm(input logic mode, input logic [AW:0] len);
    trig_mode = mode;
    length    = len;
    arm       = 1'b1;
    tick();
    arm       = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [2*DW-1:0] e);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    exp_q.push_back(e);
    tick();
    bus.rd_en   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_busy"},     busy, 0);
    check_val({tag, "_done"},     done, 0);
    check_val({tag, "_wr_count"}, wr_count, 0);
    check_val({tag, "_rd_valid"}, bus.rd_valid, 0);
    check_val({tag, "_rd_data"},  bus.rd_data, 0);
  endtask

  initial begin
    int done_at;
    bus.i_x = '0; bus.i_y = '0; bus.i_ce = 1'b0;
    bus.rd_en = 1'b0; bus.rd_addr = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // immediate trigger, length 4
    do_arm(1'b0, 11'd4);
    check_val("imm_busy", busy, 1);
    for (int k = 1; k <= 4; k++) begin
      sample(16'(k), 16'(-k));
      check_val("imm_done", done, 64'(k == 4));
    end
    check_val("imm_wr_count", wr_count, 4);
    check_val("imm_busy_end", busy, 0);
    sample(16'd99, 16'd99);
    sample(16'd98, 16'd98);
    check_val("imm_ignore_ce", wr_count, 4);
    rd(10'd2, {16'd3, 16'hFFFD});
    rd(10'd0, {16'd1, 16'hFFFF});
    rd(10'd3, {16'd4, 16'hFFFC});
    tick();
    tick();
    check_val("rd_valid_low", bus.rd_valid, 0);
    check_val("rd_data_hold", bus.rd_data, {16'd4, 16'hFFFC});

    // level-crossing trigger; the 50 sample coincides with arm and is ignored
    threshold = 16'd100;
    trig_mode = 1'b1;
    length    = 11'd2;
    arm = 1'b1; bus.i_x = 16'd1; bus.i_y = 16'd50; bus.i_ce = 1'b1;
    tick();
    arm = 1'b0; bus.i_ce = 1'b0;
    check_val("thr_armed", busy, 1);
    sample(16'd2, 16'd120);
    check_val("thr_no_trig_120", wr_count, 0);
    sample(16'd3, 16'd90);
    check_val("thr_no_trig_90", wr_count, 0);
    sample(16'd4, 16'd150);
    check_val("thr_trig_150", wr_count, 1);
    check_val("thr_capture_busy", busy, 1);
    sample(16'd5, 16'd7);
    check_val("thr_done", done, 1);
    check_val("thr_wr_count", wr_count, 2);
    rd(10'd0, {16'd4, 16'd150});
    rd(10'd1, {16'd5, 16'd7});

    // signed threshold, length 1 completes on the trigger sample
    threshold = 16'hFFF6;
    do_arm(1'b1, 11'd1);
    sample(16'd6, 16'hFFEC);
    sample(16'd7, 16'hFFF1);
    check_val("neg_no_trig", wr_count, 0);
    sample(16'd8, 16'd5);
    check_val("neg_len1_done", done, 1);
    check_val("neg_len1_count", wr_count, 1);
    rd(10'd0, {16'd8, 16'd5});

    // length 0 clamps to full depth, full-rate input
    do_arm(1'b0, 11'd0);
    done_at = -1;
    bus.i_ce = 1'b1;
    for (int k = 0; k < 1027; k++) begin
      bus.i_x = 16'(k);
      bus.i_y = 16'(k) ^ 16'h5A5A;
      tick();
      if (done && done_at < 0) done_at = k;
    end
    bus.i_ce = 1'b0;
    check_val("full_done_at", 64'(done_at), 1023);
    check_val("full_wr_count", wr_count, 1024);
    check_val("full_done", done, 1);
    rd(10'd0,    {16'd0,    16'h5A5A});
    rd(10'd511,  {16'd511,  16'd511 ^ 16'h5A5A});
    rd(10'd1023, {16'd1023, 16'd1023 ^ 16'h5A5A});

    // abort beats arm in DONE; arm during CAPTURE is ignored
    abort = 1'b1; arm = 1'b1; length = 11'd4;
    tick();
    abort = 1'b0; arm = 1'b0;
    check_val("abort_busy", busy, 0);
    check_val("abort_done", done, 0);
    check_val("abort_wr_hold", wr_count, 1024);
    tick();
    check_val("abort_stays_idle", busy, 0);
    do_arm(1'b0, 11'd8);
    for (int k = 0; k < 3; k++) sample(16'(16'h30 + k), 16'(k));
    check_val("cap_count3", wr_count, 3);
    arm = 1'b1; bus.i_x = 16'h33; bus.i_y = 16'd3; bus.i_ce = 1'b1;
    tick();
    arm = 1'b0; bus.i_ce = 1'b0;
    check_val("arm_in_capture", wr_count, 4);
    check_val("arm_in_capture_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("abort_cap_busy", busy, 0);
    check_val("abort_cap_wr", wr_count, 4);

    // reset in the middle of a capture
    do_arm(1'b0, 11'd16);
    for (int k = 0; k < 7; k++) sample(16'(k), 16'(k));
    check_val("pre_rst_count", wr_count, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    do_arm(1'b0, 11'd2);
    sample(16'h0011, 16'h0012);
    check_val("rearm_done_early", done, 0);
    check_val("rearm_count1", wr_count, 1);
    sample(16'h0021, 16'h0022);
    check_val("rearm_done", done, 1);
    check_val("rearm_count2", wr_count, 2);

    // read/write collision returns old data, later read returns new data
    do_arm(1'b0, 11'd4);
    sample(16'h00A0, 16'h00A1);
    bus.i_x = 16'h00B0; bus.i_y = 16'h00B1; bus.i_ce = 1'b1;
    bus.rd_en = 1'b1; bus.rd_addr = 10'd1;
    exp_q.push_back({16'h0021, 16'h0022});
    tick();
    bus.i_ce = 1'b0; bus.rd_en = 1'b0;
    check_val("coll_wr_count", wr_count, 2);
    rd(10'd1, {16'h00B0, 16'h00B1});

    repeat (3) tick();
    check_val("rd_queue_empty", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
